// File: rtl/calc_defs.sv
// Shared constants and types for the calculation units and the BCD converter.
package calc_defs;
    localparam int CONV_WIDTH = 32;
    localparam int BCD_DIGITS = 10;
    localparam int BCD_WIDTH  = 40;
    localparam int CNT_WIDTH  = 5;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } conv_state_t;

    // Significant-digit count: highest nonzero digit index + 1, minimum 1.
    function automatic logic [3:0] count_digits(input logic [BCD_WIDTH-1:0] bcd);
        logic [3:0] n;
        n = 4'd1;
        for (int k = 0; k < BCD_DIGITS; k++) begin
            if (bcd[4*k +: 4] != 4'd0) n = 4'(k + 1);
        end
        return n;
    endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/product_bcd_converter.sv
// 32-bit binary to 10-digit packed BCD, one shift-and-add-3 step per cycle.
module product_bcd_converter
    import calc_defs::*;
(
    input  logic                  Clk_in,
    input  logic                  Reset_in,
    input  logic                  Start_in,
    input  logic [CONV_WIDTH-1:0] Product_in32,
    output logic [BCD_WIDTH-1:0]  BCD_out40,
    output logic [3:0]            Num_digits_out4,
    output logic                  Busy_out,
    output logic                  Done_out
);
    conv_state_t           state, state_next;
    logic [CONV_WIDTH-1:0] bin_sr;
    logic [BCD_WIDTH-1:0]  bcd_work;
    logic [BCD_WIDTH-1:0]  bcd_adj;
    logic [BCD_WIDTH-1:0]  bcd_shifted;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  load;
    logic                  finish;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_work[4*g +: 4]),
            .adjusted (bcd_adj[4*g +: 4])
        );
    end

    // Binary MSB enters BCD bit 0; the adjusted top bit is always 0 for 32-bit inputs.
    assign bcd_shifted = {bcd_adj[BCD_WIDTH-2:0], bin_sr[CONV_WIDTH-1]};

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (Start_in) begin
                    load       = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt == CNT_WIDTH'(CONV_WIDTH - 1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (Reset_in) begin
            state           <= IDLE;
            bin_sr          <= '0;
            bcd_work        <= '0;
            cnt             <= '0;
            BCD_out40       <= '0;
            Num_digits_out4 <= 4'd1;
            Done_out        <= 1'b0;
        end else begin
            state    <= state_next;
            Done_out <= 1'b0;
            if (load) begin
                bin_sr   <= Product_in32;
                bcd_work <= '0;
                cnt      <= '0;
            end else if (state == CONVERT) begin
                bcd_work <= bcd_shifted;
                bin_sr   <= {bin_sr[CONV_WIDTH-2:0], 1'b0};
                cnt      <= cnt + CNT_WIDTH'(1);
            end
            if (finish) begin
                BCD_out40       <= bcd_shifted;
                Num_digits_out4 <= count_digits(bcd_shifted);
                Done_out        <= 1'b1;
            end
        end
    end

    assign Busy_out = (state == CONVERT);
endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter against a divide-by-ten reference.
module tb_product_bcd_converter;
    logic        Clk_in = 1'b0;
    logic        Reset_in;
    logic        Start_in;
    logic [31:0] Product_in32;
    logic [39:0] BCD_out40;
    logic [3:0]  Num_digits_out4;
    logic        Busy_out;
    logic        Done_out;

    int tests_run = 0;
    int tests_failed = 0;

    product_bcd_converter dut (
        .Clk_in          (Clk_in),
        .Reset_in        (Reset_in),
        .Start_in        (Start_in),
        .Product_in32    (Product_in32),
        .BCD_out40       (BCD_out40),
        .Num_digits_out4 (Num_digits_out4),
        .Busy_out        (Busy_out),
        .Done_out        (Done_out)
    );

    always #5 Clk_in = ~Clk_in;

    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        logic [39:0]     r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 10; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_nd(input logic [31:0] v);
        longint unsigned x;
        int n;
        x = v;
        n = 0;
        while (x > 0) begin
            n++;
            x = x / 10;
        end
        if (n == 0) n = 1;
        return 4'(n);
    endfunction

    // Issue one start at a negedge, then observe 40 negedges after the accept edge.
    // Sample i is taken at the negedge following edge E+(i-1).
    task automatic run_conv(input logic [31:0] v, output logic [39:0] bcd, output logic [3:0] nd,
                            output logic [39:0] mid_bcd, output int done_at, output int busy_cnt,
                            output int done_cnt);
        done_at = -1; busy_cnt = 0; done_cnt = 0; bcd = 'x; nd = 'x; mid_bcd = 'x;
        @(negedge Clk_in);
        Start_in = 1'b1;
        Product_in32 = v;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk_in);
            Start_in = 1'b0;
            Product_in32 = $urandom;
            if (Busy_out) busy_cnt++;
            if (i == 16) mid_bcd = BCD_out40;
            if (Done_out) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    bcd = BCD_out40;
                    nd = Num_digits_out4;
                end
            end
        end
    endtask

    task automatic check_conv(input string name, input logic [31:0] v, input logic [39:0] prev);
        logic [39:0] bcd, mid;
        logic [3:0]  nd;
        int da, bc, dc;
        run_conv(v, bcd, nd, mid, da, bc, dc);
        tests_run++;
        if (da !== 33 || dc !== 1) begin
            tests_failed++;
            $display("FAIL %s done_timing: done_at=%0d count=%0d, required done_at=33 count=1", name, da, dc);
        end
        tests_run++;
        if (bc !== 32) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d, required 32", name, bc);
        end
        tests_run++;
        if (bcd !== ref_bcd(v)) begin
            tests_failed++;
            $display("FAIL %s bcd: got %h, required %h (v=%0d)", name, bcd, ref_bcd(v), v);
        end
        tests_run++;
        if (nd !== ref_nd(v)) begin
            tests_failed++;
            $display("FAIL %s num_digits: got %0d, required %0d (v=%0d)", name, nd, ref_nd(v), v);
        end
        tests_run++;
        if (mid !== prev) begin
            tests_failed++;
            $display("FAIL %s hold_prev: got %h mid-run, required %h", name, mid, prev);
        end
    endtask

    task automatic test_reset();
        Reset_in = 1'b1; Start_in = 1'b0; Product_in32 = '0;
        repeat (3) @(negedge Clk_in);
        Reset_in = 1'b0;
        @(negedge Clk_in);
        tests_run++;
        if (BCD_out40 !== 40'h0 || Num_digits_out4 !== 4'd1 || Busy_out !== 1'b0 || Done_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: bcd=%h nd=%0d busy=%b done=%b, required 0/1/0/0",
                     BCD_out40, Num_digits_out4, Busy_out, Done_out);
        end
    endtask

    task automatic test_directed();
        check_conv("zero", 32'd0, 40'h0);
        check_conv("d12345", 32'd12345, 40'h0);
        tests_run++;
        if (BCD_out40 !== 40'h0000012345) begin
            tests_failed++;
            $display("FAIL d12345_literal: got %h, required 0000012345", BCD_out40);
        end
        check_conv("max", 32'hFFFFFFFF, 40'h0000012345);
        tests_run++;
        if (BCD_out40 !== 40'h4294967295 || Num_digits_out4 !== 4'd10) begin
            tests_failed++;
            $display("FAIL max_literal: got %h/%0d, required 4294967295/10", BCD_out40, Num_digits_out4);
        end
        check_conv("sq65535", 32'hFFFE0001, 40'h4294967295);
        tests_run++;
        if (BCD_out40 !== 40'h4294836225) begin
            tests_failed++;
            $display("FAIL sq65535_literal: got %h, required 4294836225", BCD_out40);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] prev;
        prev = 32'hFFFE0001;
        for (int n = 0; n < 16; n++) begin
            v = $urandom;
            if (n % 3 == 1) v = v >> $urandom_range(31, 4);
            check_conv("random", v, ref_bcd(prev));
            prev = v;
        end
    endtask

    task automatic test_ignore_start();
        int dc;
        logic [39:0] got;
        dc = 0; got = 'x;
        @(negedge Clk_in);
        Start_in = 1'b1; Product_in32 = 32'd12345;
        for (int i = 1; i <= 70; i++) begin
            @(negedge Clk_in);
            Start_in = (i == 10);
            Product_in32 = (i >= 10) ? 32'd999 : 32'd55555;
            if (Done_out) begin
                dc++;
                got = BCD_out40;
            end
        end
        Start_in = 1'b0;
        tests_run++;
        if (dc !== 1 || got !== 40'h0000012345) begin
            tests_failed++;
            $display("FAIL ignore_start: done_count=%0d bcd=%h, required 1 and 0000012345", dc, got);
        end
    endtask

    task automatic test_abort();
        logic [39:0] bcd, mid;
        logic [3:0]  nd;
        int da, bc, dc;
        dc = 0;
        @(negedge Clk_in);
        Start_in = 1'b1; Product_in32 = 32'd98765;
        for (int i = 1; i <= 15; i++) begin
            @(negedge Clk_in);
            Start_in = 1'b0;
            if (Done_out) dc++;
        end
        Reset_in = 1'b1;
        @(negedge Clk_in);
        Reset_in = 1'b0;
        tests_run++;
        if (Busy_out !== 1'b0 || BCD_out40 !== 40'h0 || Num_digits_out4 !== 4'd1 || Done_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: busy=%b bcd=%h nd=%0d done=%b, required 0/0/1/0",
                     Busy_out, BCD_out40, Num_digits_out4, Done_out);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk_in);
            if (Done_out || Busy_out) dc++;
        end
        tests_run++;
        if (dc !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: saw %0d busy/done cycles, required 0", dc);
        end
        run_conv(32'd7, bcd, nd, mid, da, bc, dc);
        tests_run++;
        if (bcd !== 40'h0000000007 || nd !== 4'd1 || da !== 33) begin
            tests_failed++;
            $display("FAIL abort_restart: bcd=%h nd=%0d done_at=%0d, required 0000000007/1/33", bcd, nd, da);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, acc;
        logic [39:0] b1, b2;
        logic [3:0]  n1, n2;
        t1 = -1; t2 = -1; acc = -1; b1 = 'x; b2 = 'x; n1 = 'x; n2 = 'x;
        @(negedge Clk_in);
        Start_in = 1'b1; Product_in32 = 32'd100;
        for (int i = 1; i <= 80; i++) begin
            @(negedge Clk_in);
            Product_in32 = 32'd42;
            if (t1 > 0 && i == t1 + 1) begin
                Start_in = 1'b0;
                if (Busy_out) acc = i;
            end
            if (Done_out) begin
                if (t1 < 0) begin
                    t1 = i; b1 = BCD_out40; n1 = Num_digits_out4;
                end else if (t2 < 0) begin
                    t2 = i; b2 = BCD_out40; n2 = Num_digits_out4;
                end
            end
        end
        Start_in = 1'b0;
        tests_run++;
        if (b1 !== 40'h0000000100 || n1 !== 4'd3) begin
            tests_failed++;
            $display("FAIL b2b_first: bcd=%h nd=%0d, required 0000000100/3", b1, n1);
        end
        tests_run++;
        if (b2 !== 40'h0000000042 || n2 !== 4'd2) begin
            tests_failed++;
            $display("FAIL b2b_second: bcd=%h nd=%0d, required 0000000042/2", b2, n2);
        end
        tests_run++;
        if (t1 !== 33 || t2 - t1 !== 33 || acc !== t1 + 1) begin
            tests_failed++;
            $display("FAIL b2b_timing: t1=%0d gap=%0d accept_seen=%0d, required 33/33/%0d",
                     t1, t2 - t1, acc, t1 + 1);
        end
    endtask

    initial begin
        Reset_in = 1'b1; Start_in = 1'b0; Product_in32 = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
